// File: rtl/pll_reset_sequencer.sv
// ============================================================================
// pll_reset_sequencer : drives the PLL reset, supervises lock, retries, faults
// Rev 1.0
// ============================================================================
`default_nettype none

module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt,
  output logic [1:0] state
);

  localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
  localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  typedef enum logic [2:0] {
    S_RESET_HOLD = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_SETTLE     = 3'd2,
    S_RUN        = 3'd3,
    S_FAULT      = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         retry_q, retry_d;
  logic [7:0]         loss_q, loss_d;
  logic               sync1_q, locked_s_q;
  logic               pll_rst_q, sys_ready_q, fault_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    loss_d  = loss_q;
    if (relock_req) begin
      state_d = S_RESET_HOLD;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        S_RESET_HOLD: begin
          if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (locked_s_q) begin
            state_d = S_SETTLE;
          end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            if (retry_q == 4'(MAX_RETRIES)) begin
              state_d = S_FAULT;
            end else begin
              retry_d = retry_q + 4'd1;
              state_d = S_RESET_HOLD;
            end
          end
        end
        S_SETTLE: begin
          if (!locked_s_q) begin
            state_d = S_WAIT_LOCK;
          end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            retry_d = 4'd0;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (!locked_s_q) begin
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
            state_d = S_RESET_HOLD;
          end
        end
        S_FAULT: ;
        default: state_d = S_RESET_HOLD;
      endcase
    end
    // Timer restarts on any state change or relock and idles in RUN/FAULT.
    if (relock_req || (state_d != state_q) || (state_q == S_RUN) || (state_q == S_FAULT))
      cnt_d = '0;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= S_RESET_HOLD;
      cnt_q       <= '0;
      retry_q     <= 4'd0;
      loss_q      <= 8'd0;
      sync1_q     <= 1'b0;
      locked_s_q  <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      sync1_q     <= pll_locked;
      locked_s_q  <= sync1_q;
      pll_rst_q   <= (state_d == S_RESET_HOLD) || (state_d == S_FAULT);
      sys_ready_q <= (state_d == S_RUN);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_ready     = sys_ready_q;
  assign fault         = fault_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;
  assign state         = (state_q == S_FAULT) ? 2'b11 : state_q[1:0];

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
// ============================================================================
// tb_pll_reset_sequencer : scoreboard bench against a phase/age reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pll_reset_sequencer;

  localparam int RSTC = 4;
  localparam int LTO  = 20;
  localparam int SETC = 8;
  localparam int MAXR = 2;

  logic       refclk     = 1'b0;
  logic       rst        = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, sys_ready, fault;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [1:0] state;

  pll_reset_sequencer #(
    .RST_CYCLES   (RSTC),
    .LOCK_TIMEOUT (LTO),
    .SETTLE_CYCLES(SETC),
    .MAX_RETRIES  (MAXR)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .relock_req   (relock_req),
    .pll_rst      (pll_rst),
    .sys_ready    (sys_ready),
    .fault        (fault),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt),
    .state        (state)
  );

  always #5 refclk = ~refclk;

  typedef struct packed {
    logic       pll_rst;
    logic       sys_ready;
    logic       fault;
    logic [3:0] retry;
    logic [7:0] loss;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: current phase, the edge it was entered on, and a
  // history of sampled pll_locked values (decisions see the one 2 edges old).
  typedef enum int {M_HOLD, M_WAIT, M_SETTLE, M_RUN, M_FAULT} phase_e;
  phase_e ph = M_HOLD;
  int     since = 0;
  int     cyc = 0;
  int     m_retries = 0;
  int     m_losses = 0;
  bit     hist[$];

  function automatic void enter(phase_e p);
    ph    = p;
    since = cyc + 1;
  endfunction

  function automatic void model_step(bit r, bit rq, bit pl);
    bit ls;
    int age;
    ls  = hist[1];
    age = cyc - since + 1;
    if (r) begin
      enter(M_HOLD);
      m_retries = 0;
      m_losses  = 0;
      hist.delete();
      hist.push_back(1'b0);
      hist.push_back(1'b0);
    end else begin
      hist.push_front(pl);
      void'(hist.pop_back());
      if (rq) begin
        enter(M_HOLD);
        m_retries = 0;
      end else begin
        case (ph)
          M_HOLD:   if (age >= RSTC) enter(M_WAIT);
          M_WAIT: begin
            if (ls) enter(M_SETTLE);
            else if (age >= LTO) begin
              if (m_retries == MAXR) enter(M_FAULT);
              else begin
                m_retries++;
                enter(M_HOLD);
              end
            end
          end
          M_SETTLE: begin
            if (!ls) enter(M_WAIT);
            else if (age >= SETC) begin
              m_retries = 0;
              enter(M_RUN);
            end
          end
          M_RUN: begin
            if (!ls) begin
              if (m_losses < 255) m_losses++;
              enter(M_HOLD);
            end
          end
          default: ;
        endcase
      end
    end
    cyc++;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.pll_rst   = (ph == M_HOLD) || (ph == M_FAULT);
    e.sys_ready = (ph == M_RUN);
    e.fault     = (ph == M_FAULT);
    e.retry     = 4'(m_retries);
    e.loss      = 8'(m_losses);
    case (ph)
      M_HOLD:   e.st = 2'b00;
      M_WAIT:   e.st = 2'b01;
      M_SETTLE: e.st = 2'b10;
      default:  e.st = 2'b11;
    endcase
    return e;
  endfunction

  task automatic step(bit r, bit rq, bit pl);
    @(negedge refclk);
    rst        = r;
    relock_req = rq;
    pll_locked = pl;
    model_step(r, rq, pl);
    sb.push_back(model_out());
  endtask

  task automatic wait_phase(phase_e target, bit pl, int limit);
    int n;
    n = 0;
    while (ph != target && n < limit) begin
      step(1'b0, 1'b0, pl);
      n++;
    end
    if (ph != target) begin
      checks++;
      errors++;
      $display("FAIL wait_phase: reached phase %0d, required %0d within %0d cycles", ph, target, limit);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare #1 after each edge.
  exp_t exp_v, got_v;
  initial begin
    forever begin
      @(posedge refclk);
      #1;
      if (sb.size() > 0) begin
        exp_v = sb.pop_front();
        got_v = {pll_rst, sys_ready, fault, retry_cnt, lock_loss_cnt, state};
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL outputs @%0t: got rst=%b rdy=%b flt=%b retry=%0d loss=%0d st=%b, required rst=%b rdy=%b flt=%b retry=%0d loss=%0d st=%b",
                   $time, got_v.pll_rst, got_v.sys_ready, got_v.fault, got_v.retry, got_v.loss, got_v.st,
                   exp_v.pll_rst, exp_v.sys_ready, exp_v.fault, exp_v.retry, exp_v.loss, exp_v.st);
        end
      end
    end
  end

  bit rv;
  int rn;
  int guard;

  initial begin
    hist.push_back(1'b0);
    hist.push_back(1'b0);

    // Power-on reset, then a first clean acquisition.
    repeat (3) step(1'b1, 1'b0, 1'b0);
    wait_phase(M_WAIT, 1'b0, 50);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    wait_phase(M_RUN, 1'b1, 50);
    repeat (5) step(1'b0, 1'b0, 1'b1);

    // Never locks: retries exhaust into FAULT, which holds until relock.
    step(1'b0, 1'b1, 1'b0);
    wait_phase(M_FAULT, 1'b0, 200);
    repeat (100) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // One-cycle lock glitch inside SETTLE, then a full clean settle.
    wait_phase(M_SETTLE, 1'b1, 100);
    repeat (4) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    wait_phase(M_RUN, 1'b1, 100);

    // Repeated lock losses in RUN saturate the loss counter.
    for (int i = 0; i < 260; i++) begin
      wait_phase(M_RUN, 1'b1, 100);
      wait_phase(M_HOLD, 1'b0, 10);
    end

    // Relock arriving on the very edge the synchronised lock drops.
    wait_phase(M_RUN, 1'b1, 100);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Reset in the middle of WAIT_LOCK with one retry consumed.
    guard = 0;
    while (!(ph == M_WAIT && m_retries == 1) && guard < 200) begin
      step(1'b0, 1'b0, 1'b0);
      guard++;
    end
    if (!(ph == M_WAIT && m_retries == 1)) begin
      checks++;
      errors++;
      $display("FAIL reach_wait_retry1: phase %0d retries %0d, required phase %0d retries 1", ph, m_retries, M_WAIT);
    end
    repeat (5) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // Randomised lock behaviour with sporadic relock and reset.
    for (int i = 0; i < 150; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rn = int'($urandom_range(1, 40));
      for (int k = 0; k < rn; k++) step(1'b0, ($urandom_range(0, 63) == 0), rv);
      if ($urandom_range(0, 19) == 0) step(1'b1, 1'b0, rv);
    end

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(negedge refclk);
      guard++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
